// File: rtl/writeback_stage.sv
// Writeback stage: one-entry pipeline register between memory access and the register file.
// It formats load data, flags misaligned loads and counts retired instructions.
module writeback_stage #(
    parameter int INSTRET_W = 64,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 halt,
    input  logic                 flush,
    input  logic                 in_reg_write,
    input  logic [4:0]           in_rd,
    input  logic [1:0]           in_wb_sel,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_load_word,
    input  logic [2:0]           in_load_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 reg_write_en,
    output logic [4:0]           reg_write_dest,
    output logic [XLEN-1:0]      reg_write_data,
    output logic                 exc_misaligned,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_RSVD = 2'b11;

    // Undefined load encodings are reported as misaligned so they never write.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic m;
        case (f3)
            3'b000, 3'b100: m = 1'b0;
            3'b001, 3'b101: m = lo[0];
            3'b010:         m = (lo != 2'b00);
            default:        m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            3'b010:  r = word;
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    logic            accept_s;
    logic            misal_s;
    logic            retire_s;
    logic            en_s;
    logic [XLEN-1:0] result_s;
    logic [XLEN-1:0] data_s;

    logic            wb_valid_r;
    logic            wb_en_r;
    logic            wb_exc_r;
    logic            wb_retire_r;
    logic [4:0]      wb_rd_r;
    logic [XLEN-1:0] wb_data_r;
    logic [INSTRET_W-1:0] instret_r;

    assign in_ready = ~halt;

    // Decode the incoming instruction so the pipeline register holds ready-to-drive values.
    always_comb begin
        accept_s = in_valid & ~halt & ~flush;
        misal_s  = (in_wb_sel == WB_LOAD) & is_misaligned(in_load_funct3, in_addr_lo);
        retire_s = ~misal_s & (in_wb_sel != WB_RSVD);
        en_s     = in_reg_write & (in_rd != 5'd0) & retire_s;
        case (in_wb_sel)
            WB_ALU:  result_s = in_alu_result;
            WB_LOAD: result_s = load_extract(in_load_funct3, in_addr_lo, in_load_word);
            WB_PC4:  result_s = in_pc + 32'd4;
            default: result_s = 32'h00000000;
        endcase
        if (en_s) begin
            data_s = result_s;
        end else begin
            data_s = 32'h00000000;
        end
    end

    // Pipeline register: loads on accept, otherwise empties; rd is held until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_r  <= 1'b0;
            wb_en_r     <= 1'b0;
            wb_exc_r    <= 1'b0;
            wb_retire_r <= 1'b0;
            wb_rd_r     <= 5'd0;
            wb_data_r   <= 32'h00000000;
        end else if (accept_s) begin
            wb_valid_r  <= 1'b1;
            wb_en_r     <= en_s;
            wb_exc_r    <= misal_s;
            wb_retire_r <= retire_s;
            wb_rd_r     <= in_rd;
            wb_data_r   <= data_s;
        end else begin
            wb_valid_r  <= 1'b0;
            wb_en_r     <= 1'b0;
            wb_exc_r    <= 1'b0;
            wb_retire_r <= 1'b0;
            wb_rd_r     <= wb_rd_r;
            wb_data_r   <= 32'h00000000;
        end
    end

    // Retired-instruction counter; counts at the edge where the register file samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (wb_valid_r & wb_retire_r) begin
            instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    assign reg_write_en   = wb_valid_r & wb_en_r;
    assign reg_write_dest = wb_rd_r;
    assign reg_write_data = wb_data_r;
    assign exc_misaligned = wb_valid_r & wb_exc_r;
    assign instret        = instret_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected writes,
// a negedge monitor pops and compares whenever a write or exception is presented.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        halt = 1'b0;
    logic        flush = 1'b0;
    logic        in_reg_write = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic [1:0]  in_wb_sel = 2'b00;
    logic [31:0] in_alu_result = 32'h0;
    logic [31:0] in_load_word = 32'h0;
    logic [2:0]  in_load_funct3 = 3'b000;
    logic [1:0]  in_addr_lo = 2'b00;
    logic [31:0] in_pc = 32'h0;
    logic        reg_write_en;
    logic [4:0]  reg_write_dest;
    logic [31:0] reg_write_data;
    logic        exc_misaligned;
    logic [63:0] instret;

    typedef struct packed {
        logic        en;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    writeback_stage #(.INSTRET_W(64), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .halt(halt),
        .flush(flush), .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_load_word(in_load_word),
        .in_load_funct3(in_load_funct3), .in_addr_lo(in_addr_lo), .in_pc(in_pc),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .exc_misaligned(exc_misaligned), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write/exception must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (!reg_write_en) check("data_zero_when_idle", 64'(reg_write_data), 64'd0);
            if (reg_write_en || exc_misaligned) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'({reg_write_en, exc_misaligned}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_en", 64'(reg_write_en), 64'(e.en));
                    check("sb_exc", 64'(exc_misaligned), 64'(e.exc));
                    if (e.en) begin
                        check("sb_dest", 64'(reg_write_dest), 64'(e.dest));
                        check("sb_data", 64'(reg_write_data), 64'(e.data));
                    end
                end
            end
        end
    end

    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] word, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] pc,
                         input logic exp_en, input logic [31:0] exp_data, input logic exp_exc);
        exp_t e;
        in_reg_write = rw; in_rd = rd; in_wb_sel = sel; in_alu_result = alu;
        in_load_word = word; in_load_funct3 = f3; in_addr_lo = lo; in_pc = pc;
        in_valid = 1'b1;
        if (!halt && !flush && (exp_en || exp_exc)) begin
            e.en = exp_en; e.dest = rd; e.data = exp_data; e.exc = exp_exc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_en", 64'(reg_write_en), 64'd0);
        check("rst_dest", 64'(reg_write_dest), 64'd0);
        check("rst_data", 64'(reg_write_data), 64'd0);
        check("rst_exc", 64'(exc_misaligned), 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        halt = 1'b1; #1;
        check("rst_ready_halt", 64'(in_ready), 64'd0);
        halt = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        check("post_rst_en", 64'(reg_write_en), 64'd0);

        // ALU and load formatting
        issue(1'b1, 5'd5, 2'b00, 32'h12345678, 32'h0, 3'b000, 2'b00, 32'h0, 1'b1, 32'h12345678, 1'b0);
        idle(2);
        check("alu_instret", instret, 64'd1);
        issue(1'b1, 5'd1, 2'b01, 32'h0, 32'h80FFFFFF, 3'b000, 2'b11, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
        issue(1'b1, 5'd2, 2'b01, 32'h0, 32'h80FFFFFF, 3'b100, 2'b11, 32'h0, 1'b1, 32'h00000080, 1'b0);
        issue(1'b1, 5'd4, 2'b01, 32'h0, 32'hBEEF0000, 3'b101, 2'b10, 32'h0, 1'b1, 32'h0000BEEF, 1'b0);
        issue(1'b1, 5'd6, 2'b01, 32'h0, 32'h12348001, 3'b001, 2'b00, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
        issue(1'b1, 5'd7, 2'b01, 32'h0, 32'hCAFEBABE, 3'b010, 2'b00, 32'h0, 1'b1, 32'hCAFEBABE, 1'b0);
        idle(2);
        check("loads_instret", instret, 64'd6);

        // Misaligned LW: exception only, no retire
        issue(1'b1, 5'd3, 2'b01, 32'h0, 32'hCAFEBABE, 3'b010, 2'b01, 32'h0, 1'b0, 32'h0, 1'b1);
        idle(2);
        check("misal_instret", instret, 64'd6);

        // rd=0 retires without writing
        issue(1'b1, 5'd0, 2'b00, 32'hFFFFFFFF, 32'h0, 3'b000, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rd0_data", 64'(reg_write_data), 64'd0);
        idle(2);
        check("rd0_instret", instret, 64'd7);

        // Reserved wb_sel neither writes nor counts; reg_write=0 counts only
        issue(1'b1, 5'd9, 2'b11, 32'h11111111, 32'h0, 3'b000, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(2);
        check("rsvd_instret", instret, 64'd7);
        issue(1'b0, 5'd10, 2'b00, 32'h22222222, 32'h0, 3'b000, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(2);
        check("nowrite_instret", instret, 64'd8);

        // Flush and halt discard incoming instructions
        flush = 1'b1;
        issue(1'b1, 5'd20, 2'b00, 32'h33333333, 32'h0, 3'b000, 2'b00, 32'h0, 1'b1, 32'h33333333, 1'b0);
        flush = 1'b0;
        check("flush_en", 64'(reg_write_en), 64'd0);
        halt = 1'b1; #1;
        check("halt_ready", 64'(in_ready), 64'd0);
        issue(1'b1, 5'd21, 2'b00, 32'h44444444, 32'h0, 3'b000, 2'b00, 32'h0, 1'b1, 32'h44444444, 1'b0);
        check("halt_en", 64'(reg_write_en), 64'd0);
        halt = 1'b0;
        idle(2);
        check("flush_halt_instret", instret, 64'd8);

        // Halt after capture does not stop the captured entry
        issue(1'b1, 5'd14, 2'b00, 32'h0BADF00D, 32'h0, 3'b000, 2'b00, 32'h0, 1'b1, 32'h0BADF00D, 1'b0);
        halt = 1'b1;
        check("halt_keep_en", 64'(reg_write_en), 64'd1);
        idle(1);
        halt = 1'b0;
        idle(1);
        check("halt_keep_instret", instret, 64'd9);

        // Back-to-back: one write per cycle
        issue(1'b1, 5'd11, 2'b00, 32'hAAAA0001, 32'h0, 3'b000, 2'b00, 32'h0, 1'b1, 32'hAAAA0001, 1'b0);
        check("b2b_dest0", 64'({reg_write_en, reg_write_dest}), 64'({1'b1, 5'd11}));
        issue(1'b1, 5'd12, 2'b00, 32'hAAAA0002, 32'h0, 3'b000, 2'b00, 32'h0, 1'b1, 32'hAAAA0002, 1'b0);
        check("b2b_dest1", 64'({reg_write_en, reg_write_dest}), 64'({1'b1, 5'd12}));
        issue(1'b1, 5'd13, 2'b00, 32'hAAAA0003, 32'h0, 3'b000, 2'b00, 32'h0, 1'b1, 32'hAAAA0003, 1'b0);
        check("b2b_dest2", 64'({reg_write_en, reg_write_dest}), 64'({1'b1, 5'd13}));
        idle(2);
        check("b2b_instret", instret, 64'd12);

        // Reset mid-write drops the write immediately
        issue(1'b1, 5'd15, 2'b00, 32'h55555555, 32'h0, 3'b000, 2'b00, 32'h0, 1'b1, 32'h55555555, 1'b0);
        #1;
        check("midrst_before_en", 64'(reg_write_en), 64'd1);
        rst = 1'b0;
        #1;
        check("midrst_en", 64'(reg_write_en), 64'd0);
        check("midrst_data", 64'(reg_write_data), 64'd0);
        check("midrst_instret", instret, 64'd0);
        sb.delete();
        #1;
        rst = 1'b1;
        idle(1);
        check("midrst_after_instret", instret, 64'd0);

        // PC+4 wraps modulo 2^32
        issue(1'b1, 5'd8, 2'b10, 32'h0, 32'h0, 3'b000, 2'b00, 32'hFFFFFFFC, 1'b1, 32'h00000000, 1'b0);
        check("pc4_en", 64'(reg_write_en), 64'd1);
        idle(2);
        check("pc4_instret", instret, 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
